// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int MAX_LEN   = 63;
  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int BYTE_W    = 8;
  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_PLD,
    ST_PAR,
    ST_GAP
  } state_e;

  // Header byte: length in the upper bits, destination port in the lower bits.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload buffer: one synchronous write port, one asynchronous read port.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem_q [BUF_DEPTH];

  // Write port; contents are never cleared, stale data is simply overwritten.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and
// parity to the router, honouring its busy stall, followed by an idle gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [BYTE_W-1:0] pld_data,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [BYTE_W-1:0] data_in,
  output logic              req_err,
  output logic              pkt_done,
  output logic [7:0]        err_cnt
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [BUF_AW-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0] par_q, par_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              req_err_q, req_err_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              err_seen_q, err_seen_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              buf_we;
  logic [BUF_AW-1:0] buf_raddr;
  logic [BYTE_W-1:0] buf_rdata;
  logic [LEN_W-1:0]  len_last;

  assign len_last = len_q - LEN_W'(1);

  router_tx_buf u_buf (
    .clk   (clock),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (pld_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Next-state and next-output logic; data_d/vld_d describe what the router
  // sees in the state being entered, so the outputs stay registered.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    par_d      = par_q;
    data_d     = data_q;
    vld_d      = vld_q;
    req_err_d  = 1'b0;
    gap_d      = gap_q;
    err_seen_d = err_seen_q;
    err_cnt_d  = err_cnt_q;
    buf_we     = 1'b0;
    buf_raddr  = '0;
    req_ready  = 1'b0;
    pld_ready  = 1'b0;
    pkt_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        data_d    = '0;
        vld_d     = 1'b0;
        if (req_valid) begin
          addr_d = req_addr;
          len_d  = req_len;
          if (req_len == '0 || req_addr == 2'd3) begin
            req_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = '0;
            // Parity starts from the header and folds in payload as it loads.
            par_d   = hdr_byte(req_len, req_addr);
          end
        end
      end

      ST_LOAD: begin
        pld_ready = 1'b1;
        if (pld_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ pld_data;
          if (idx_q == len_last) begin
            state_d = ST_HDR;
            data_d  = hdr_byte(len_q, addr_q);
            vld_d   = 1'b1;
          end else begin
            idx_d = idx_q + BUF_AW'(1);
          end
        end
      end

      ST_HDR: begin
        buf_raddr = '0;
        if (!busy) begin
          state_d = ST_PLD;
          idx_d   = '0;
          data_d  = buf_rdata;
          vld_d   = 1'b1;
        end
      end

      ST_PLD: begin
        // Look one byte ahead so the next byte follows with no gap.
        buf_raddr = idx_q + BUF_AW'(1);
        if (!busy) begin
          if (idx_q == len_last) begin
            state_d = ST_PAR;
            data_d  = par_q;
            vld_d   = 1'b0;
          end else begin
            idx_d  = idx_q + BUF_AW'(1);
            data_d = buf_rdata;
          end
        end
      end

      ST_PAR: begin
        if (!busy) begin
          pkt_done   = 1'b1;
          data_d     = '0;
          vld_d      = 1'b0;
          gap_d      = '0;
          err_seen_d = 1'b0;
          state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        data_d = '0;
        vld_d  = 1'b0;
        // One error count per packet no matter how long err stays high.
        if (err && !err_seen_q) begin
          err_seen_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end

      default: begin
        state_d = ST_IDLE;
        data_d  = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      par_q      <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      req_err_q  <= 1'b0;
      gap_q      <= '0;
      err_seen_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      req_err_q  <= req_err_d;
      gap_q      <= gap_d;
      err_seen_q <= err_seen_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_valid = vld_q;
  assign data_in   = data_q;
  assign req_err   = req_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       req_err;
  logic       pkt_done;
  logic [7:0] err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] pl [64];
  logic [7:0] got [$];

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pld_data  (pld_data),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .busy      (busy),
    .err       (err),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .req_err   (req_err),
    .pkt_done  (pkt_done),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  // Sends one packet and collects every transferred byte into got.
  // Entered and left 1 unit after a rising edge with the DUT in IDLE.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l,
                         input logic [7:0] stall_byte, input int stall_n,
                         input logic gap_err, input bit full);
    logic [7:0] exp_q [$];
    logic [7:0] par;
    int  cyc, stall_left, held;
    bit  done;
    got.delete();
    req_valid = 1'b1; req_addr = a; req_len = l;
    samp();
    if (full) chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      pld_valid = 1'b1; pld_data = pl[i];
      samp();
      if (full && i == 0) chk("pld_ready_load", 32'(pld_ready), 32'd1);
      step();
    end
    pld_valid = 1'b0;

    par = {l, a};
    exp_q.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(pl[i]);
      par = par ^ pl[i];
    end
    exp_q.push_back(par);

    cyc = 0; stall_left = stall_n; held = 0; done = 0;
    while (!done && cyc < 400) begin
      busy = (pkt_valid && data_in == stall_byte && stall_left > 0);
      if (busy) stall_left--;
      samp();
      if (pkt_valid && data_in == stall_byte) held++;
      if (pkt_valid && !busy) got.push_back(data_in);
      if (pkt_done) begin
        if (full) chk("pkt_valid_at_parity", 32'(pkt_valid), 32'd0);
        got.push_back(data_in);
        done = 1;
      end
      step();
      cyc++;
    end
    busy = 1'b0;

    chk("pkt_done_seen", 32'(done), 32'd1);
    if (full) begin
      chk("byte_count", 32'(got.size()), 32'(int'(l) + 2));
      chk("xfer_cycles", 32'(cyc), 32'(int'(l) + 2 + stall_n));
      if (stall_n > 0) chk("stall_hold_cycles", 32'(held), 32'(stall_n + 1));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk($sformatf("byte[%0d]", i), 32'(got[i]), 32'(exp_q[i]));
    end

    for (int g = 0; g < 2; g++) begin
      err = gap_err;
      samp();
      if (full) begin
        chk("gap_data", 32'(data_in), 32'd0);
        chk("gap_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("gap_req_ready", 32'(req_ready), 32'd0);
      end
      step();
    end
    err = 1'b0;
    samp();
    if (full) chk("back_to_idle", 32'(req_ready), 32'd1);
    step();
  endtask

  initial begin
    int k;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pld_data = '0; pld_valid = 1'b0; busy = 1'b0; err = 1'b0;

    // Reset state
    step(); step();
    samp();
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data_in",   32'(data_in),   32'd0);
    chk("rst_req_err",   32'(req_err),   32'd0);
    chk("rst_pkt_done",  32'(pkt_done),  32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pld_ready", 32'(pld_ready), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Basic packet: addr 1, len 3. Header {3,1}=0x0D; parity 0x0D^0x11^0x22^0x33 = 0x0D.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 8'h22, 0, 1'b0, 1'b1);
    if (got.size() == 5) begin
      chk("basic_hdr_const", 32'(got[0]), 32'h0D);
      chk("basic_par_const", 32'(got[4]), 32'h0D);
    end

    // Same packet with 4 stall cycles while 0x22 is presented.
    run_pkt(2'd1, 6'd3, 8'h22, 4, 1'b0, 1'b1);
    chk("no_err_without_err", 32'(err_cnt), 32'd0);

    // Dropped requests: bad address, then zero length.
    for (int t = 0; t < 2; t++) begin
      req_valid = 1'b1;
      req_addr  = (t == 0) ? 2'd3 : 2'd0;
      req_len   = (t == 0) ? 6'd5 : 6'd0;
      samp();
      chk("req_err_before", 32'(req_err), 32'd0);
      step();
      req_valid = 1'b0;
      samp();
      chk("req_err_pulse",    32'(req_err),   32'd1);
      chk("req_err_pkt_vld",  32'(pkt_valid), 32'd0);
      chk("req_err_pld_rdy",  32'(pld_ready), 32'd0);
      chk("req_err_stay_idle", 32'(req_ready), 32'd1);
      step();
      samp();
      chk("req_err_once",     32'(req_err),   32'd0);
      chk("req_err_pld_rdy2", 32'(pld_ready), 32'd0);
      step();
    end

    // Maximum length: header 0xFC, parity 0xFC ^ (0x00..0x3E) = 0xFC ^ 0x3F = 0xC3.
    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    run_pkt(2'd0, 6'd63, 8'hFF, 0, 1'b0, 1'b1);
    if (got.size() == 65) begin
      chk("max_hdr_const", 32'(got[0]),  32'hFC);
      chk("max_par_const", 32'(got[64]), 32'hC3);
    end

    // Reset in the middle of the payload phase.
    pl[0] = 8'hA1; pl[1] = 8'hA2; pl[2] = 8'hA3; pl[3] = 8'hA4; pl[4] = 8'hA5;
    req_valid = 1'b1; req_addr = 2'd2; req_len = 6'd5;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pld_valid = 1'b1; pld_data = pl[i];
      step();
    end
    pld_valid = 1'b0;
    k = 0;
    while (!(pkt_valid && data_in == 8'hA3) && k < 20) begin
      step();
      k++;
    end
    chk("reached_mid_pld", 32'(k < 20), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    samp();
    chk("mid_rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_data_in",   32'(data_in),   32'd0);
    step();
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    run_pkt(2'd2, 6'd2, 8'hFF, 0, 1'b0, 1'b1);

    // err for both gap cycles on 300 packets: one count per packet, saturating.
    pl[0] = 8'h77;
    for (int p = 1; p <= 300; p++) begin
      run_pkt(2'd0, 6'd1, 8'hFF, 0, 1'b1, 1'b0);
      if (p == 1 || p == 2 || p == 254 || p == 255 || p == 256 || p == 300)
        chk($sformatf("err_cnt_after_%0d", p), 32'(err_cnt), 32'((p > 255) ? 255 : p));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
